// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light controller: main road rests green, a latched side-road
// request runs one timed MY -> AR1 -> SG -> SY -> AR2 cycle back to MG.
module traffic_light_ctrl #(
  parameter int T_MG = 8,
  parameter int T_Y  = 3,
  parameter int T_AR = 2,
  parameter int T_SG = 6,
  parameter int CW   = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Req,
  output logic MainR,
  output logic MainY,
  output logic MainG,
  output logic SideR,
  output logic SideY,
  output logic SideG,
  output logic Pending
);

  typedef enum logic [2:0] {
    S_MG  = 3'd0,
    S_MY  = 3'd1,
    S_AR1 = 3'd2,
    S_SG  = 3'd3,
    S_SY  = 3'd4,
    S_AR2 = 3'd5
  } state_t;

  localparam logic [CW-1:0] LD_MG = CW'(T_MG - 1);
  localparam logic [CW-1:0] LD_Y  = CW'(T_Y - 1);
  localparam logic [CW-1:0] LD_AR = CW'(T_AR - 1);
  localparam logic [CW-1:0] LD_SG = CW'(T_SG - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic          tmr_zero;

  assign tmr_zero = (timer_q == '0);

  // Timer saturates at zero; every transition reloads it for the state being entered.
  always_comb begin
    state_d   = state_q;
    timer_d   = tmr_zero ? '0 : timer_q - CW'(1);
    pending_d = pending_q | Req;
    case (state_q)
      S_MG: begin
        if (tmr_zero && (pending_q || Req)) begin
          state_d = S_MY;
          timer_d = LD_Y;
        end
      end
      S_MY: begin
        if (tmr_zero) begin
          state_d = S_AR1;
          timer_d = LD_AR;
        end
      end
      S_AR1: begin
        if (tmr_zero) begin
          state_d   = S_SG;
          timer_d   = LD_SG;
          pending_d = 1'b0;   // serving the request beats a same-edge Req
        end
      end
      S_SG: begin
        if (tmr_zero) begin
          state_d = S_SY;
          timer_d = LD_Y;
        end
      end
      S_SY: begin
        if (tmr_zero) begin
          state_d = S_AR2;
          timer_d = LD_AR;
        end
      end
      S_AR2: begin
        if (tmr_zero) begin
          state_d = S_MG;
          timer_d = LD_MG;
        end
      end
      default: begin
        state_d = S_MG;
        timer_d = LD_MG;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_MG;
      timer_q   <= LD_MG;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  // Lamps are a pure decode of the state register, so they only move on a clock edge.
  always_comb begin
    MainR = 1'b0;
    MainY = 1'b0;
    MainG = 1'b0;
    SideR = 1'b0;
    SideY = 1'b0;
    SideG = 1'b0;
    case (state_q)
      S_MG: begin
        MainG = 1'b1;
        SideR = 1'b1;
      end
      S_MY: begin
        MainY = 1'b1;
        SideR = 1'b1;
      end
      S_SG: begin
        MainR = 1'b1;
        SideG = 1'b1;
      end
      S_SY: begin
        MainR = 1'b1;
        SideY = 1'b1;
      end
      default: begin
        MainR = 1'b1;
        SideR = 1'b1;
      end
    endcase
  end

  assign Pending = pending_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl at default timing; lamp invariant checked every cycle.
module tb_traffic_light_ctrl;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Req   = 1'b0;
  logic MainR, MainY, MainG, SideR, SideY, SideG, Pending;

  int n_vec = 0;
  int n_err = 0;
  bit inv_en = 1'b0;

  localparam logic [5:0] L_MG = 6'b001_100;
  localparam logic [5:0] L_MY = 6'b010_100;
  localparam logic [5:0] L_AR = 6'b100_100;
  localparam logic [5:0] L_SG = 6'b100_001;
  localparam logic [5:0] L_SY = 6'b100_010;

  traffic_light_ctrl dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Req    (Req),
    .MainR  (MainR),
    .MainY  (MainY),
    .MainG  (MainG),
    .SideR  (SideR),
    .SideY  (SideY),
    .SideG  (SideG),
    .Pending(Pending)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One edge with Reset high; afterwards the bench is in cycle 0.
  task automatic do_reset(input logic req_during);
    Reset = 1'b1;
    Req   = req_during;
    tick();
    Reset = 1'b0;
    Req   = 1'b0;
  endtask

  // Hand timeline at defaults: MY starts at cycle s, then MY 3, AR 2, SG 6, SY 3, AR 2, MG.
  function automatic logic [5:0] lamps_at(input int c, input int s);
    if (c < s)           return L_MG;
    else if (c < s + 3)  return L_MY;
    else if (c < s + 5)  return L_AR;
    else if (c < s + 11) return L_SG;
    else if (c < s + 14) return L_SY;
    else if (c < s + 16) return L_AR;
    else                 return L_MG;
  endfunction

  task automatic chk(input string tag, input int c, input logic [5:0] exp_l, input logic exp_p);
    logic [6:0] obs, exp_v;
    obs   = {MainR, MainY, MainG, SideR, SideY, SideG, Pending};
    exp_v = {exp_l, exp_p};
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s cycle %0d: got lamps/pend %b, expected %b", tag, c, obs, exp_v);
    end
  endtask

  always @(negedge Clock) begin
    if (inv_en) begin
      n_vec++;
      assert ($onehot({MainR, MainY, MainG}) && $onehot({SideR, SideY, SideG}) && (MainR || SideR))
      else begin
        n_err++;
        $error("FAIL invariant: got %b, expected one lamp per road and a red",
               {MainR, MainY, MainG, SideR, SideY, SideG});
      end
    end
  end

  initial begin
    do_reset(1'b1);
    inv_en = 1'b1;

    // Idle: no request, main green forever.
    for (int c = 0; c < 40; c++) begin
      Req = 1'b0;
      chk("idle", c, L_MG, 1'b0);
      tick();
    end

    // Single pulse in cycle 2: MY at 8, SG 13-18, back to MG at 24.
    do_reset(1'b0);
    for (int c = 0; c < 36; c++) begin
      Req = (c == 2);
      chk("pulse2", c, lamps_at(c, 8), (c >= 3 && c <= 12));
      tick();
    end

    // Pulse in cycle 20 after MG timer expired: MY at 21, SG 26-31.
    do_reset(1'b0);
    for (int c = 0; c < 42; c++) begin
      Req = (c == 20);
      chk("pulse20", c, lamps_at(c, 21), (c >= 21 && c <= 25));
      tick();
    end

    // Req held high: period 24, Pending only drops on SG entry cycle.
    do_reset(1'b0);
    for (int c = 0; c < 72; c++) begin
      Req = 1'b1;
      chk("held", c, lamps_at(c % 24, 8), !(c == 0 || (c % 24) == 13));
      tick();
    end

    // Second Req exactly on the SG-entry edge is swallowed; MG then holds.
    do_reset(1'b0);
    for (int c = 0; c < 50; c++) begin
      Req = (c == 2) || (c == 12);
      chk("sg_edge", c, lamps_at(c, 8), (c >= 3 && c <= 12));
      tick();
    end

    // Reset during SG (cycle 15) with Req high: Req ignored, MG from 16 holds.
    do_reset(1'b0);
    for (int c = 0; c < 15; c++) begin
      Req = (c == 2);
      chk("rst_mid", c, lamps_at(c, 8), (c >= 3 && c <= 12));
      tick();
    end
    chk("rst_mid", 15, L_SG, 1'b0);
    do_reset(1'b1);
    for (int c = 16; c < 34; c++) begin
      Req = 1'b0;
      chk("after_rst", c, L_MG, 1'b0);
      tick();
    end

    inv_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
